// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core fetch/data ports plus unified RAM port of the arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 17);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_ready_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [31:0]       d_addr_i;
  logic [3:0]        d_sel_i;
  logic [31:0]       d_wdata_i;
  logic [31:0]       d_rdata_o;
  logic              d_ready_o;
  logic              stall_req_o;
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_sel_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i, mem_rdata_i,
    output if_data_o, if_ready_o, d_rdata_o, d_ready_o, stall_req_o,
           mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o
  );
  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i, mem_rdata_i,
    input  if_data_o, if_ready_o, d_rdata_o, d_ready_o, stall_req_o,
           mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one write-first single-port RAM between fetch and data ports
module mem_port_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_D} resp_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  resp_e       r_resp, w_resp_nxt;
  logic [3:0]  r_starve, w_starve_nxt;
  logic        r_d_store;
  logic [31:0] r_if_data, r_d_data;
  logic        w_if_el, w_d_el, w_gnt_if, w_gnt_d, w_if_rdy, w_d_rdy;
  logic        w_unused;
  assign w_unused = ^{bus.if_addr_i[31:ADDR_W+2], bus.if_addr_i[1:0],
                      bus.d_addr_i[31:ADDR_W+2], bus.d_addr_i[1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp    <= RESP_NONE;
      r_starve  <= '0;
      r_d_store <= 1'b0;
      r_if_data <= '0;
      r_d_data  <= '0;
    end else begin
      r_resp   <= w_resp_nxt;
      r_starve <= w_starve_nxt;
      if (w_gnt_d) r_d_store <= bus.d_we_i;
      if (w_if_rdy) r_if_data <= bus.if_data_o;
      if (w_d_rdy) r_d_data <= bus.d_rdata_o;
    end
  end
  // A request is not reissued in its own response cycle; grants are held off while in reset.
  always_comb begin
    w_if_rdy         = r_resp == RESP_IF;
    w_d_rdy          = r_resp == RESP_D;
    w_if_el          = bus.if_req_i && !w_if_rdy;
    w_d_el           = bus.d_req_i && !w_d_rdy;
    w_gnt_d          = rst_n && w_d_el && !(w_if_el && r_starve == LIMIT);
    w_gnt_if         = rst_n && w_if_el && !w_gnt_d;
    w_resp_nxt       = w_gnt_d ? RESP_D : w_gnt_if ? RESP_IF : RESP_NONE;
    w_starve_nxt     = (!bus.if_req_i || w_gnt_if) ? 4'd0 :
                       (w_gnt_d && w_if_el && r_starve != LIMIT) ? r_starve + 4'd1 : r_starve;
    bus.if_ready_o   = w_if_rdy;
    bus.d_ready_o    = w_d_rdy;
    bus.if_data_o    = w_if_rdy ? bus.mem_rdata_i : r_if_data;
    bus.d_rdata_o    = w_d_rdy ? (r_d_store ? 32'd0 : bus.mem_rdata_i) : r_d_data;
    bus.stall_req_o  = (bus.if_req_i && !w_if_rdy) || (bus.d_req_i && !w_d_rdy);
    bus.mem_ce_o     = w_gnt_d || w_gnt_if;
    bus.mem_we_o     = w_gnt_d && bus.d_we_i;
    bus.mem_addr_o   = w_gnt_d ? bus.d_addr_i[ADDR_W+1:2] : w_gnt_if ? bus.if_addr_i[ADDR_W+1:2] : '0;
    bus.mem_sel_o    = w_gnt_d ? bus.d_sel_i : w_gnt_if ? 4'hF : 4'h0;
    bus.mem_wdata_o  = w_gnt_d ? bus.d_wdata_i : 32'd0;
  end
endmodule
